// File: rtl/pooling_unit_if.sv
// Pixel stream bundle between a feature-map producer, the pooling engine and the next layer.
// The master side drives input pixels; the slave side is the pooling engine.
interface pooling_unit_if #(
    parameter int unsigned data_width = 32
);
    logic [data_width-1:0] data_in;
    logic                  valid_in;
    logic [data_width-1:0] data_out;
    logic                  valid_out;
    logic                  frame_done;

    modport master (
        output data_in,
        output valid_in,
        input  data_out,
        input  valid_out,
        input  frame_done
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output data_out,
        output valid_out,
        output frame_done
    );
endinterface

// File: rtl/pooling_unit.sv
// Streaming 2x2 stride-2 max/average pooling over a raster-order feature map.
// A horizontal pair register feeds a half-width line buffer; one registered output per 2x2 window.
module pooling_unit #(
    parameter int unsigned data_width = 32,
    parameter int unsigned width      = 4,
    parameter int unsigned height     = 4,
    parameter int unsigned mode       = 0,
    parameter int unsigned is_signed  = 1
) (
    input  logic           clk,
    input  logic           reset,
    pooling_unit_if.slave  bus
);
    localparam int unsigned hw    = data_width + 1;
    localparam int unsigned sw    = data_width + 2;
    localparam int unsigned col_w = (width > 1) ? $clog2(width) : 1;
    localparam int unsigned row_w = (height > 1) ? $clog2(height) : 1;
    localparam int unsigned lb_n  = width / 2;
    localparam int unsigned lb_w  = (lb_n > 1) ? $clog2(lb_n) : 1;

    // Odd or degenerate frame geometry cannot be pooled 2x2.
    if ((width % 2) != 0 || width < 2 || (height % 2) != 0 || height < 2) begin : g_bad_dims
        $fatal(1, "pooling_unit: width and height must be even and >= 2");
    end

    logic [col_w-1:0]      col;
    logic [row_w-1:0]      row;
    logic [data_width-1:0] pair_q;
    logic [hw-1:0]         line_buf [lb_n];
    logic [data_width-1:0] data_q;
    logic                  valid_q;
    logic                  done_q;

    logic [lb_w-1:0]       lb_idx_c;
    logic                  last_col_c;
    logic                  last_row_c;
    logic                  window_end_c;
    logic [hw-1:0]         px_ext_c;
    logic [hw-1:0]         pair_ext_c;
    logic [hw-1:0]         lb_rd_c;
    logic [hw-1:0]         h_c;
    logic [sw-1:0]         sum_c;
    logic [data_width-1:0] result_c;

    // Operands are widened by one bit (sign or zero) so a single signed compare serves both arithmetic modes.
    always_comb begin
        lb_idx_c     = lb_w'(col >> 1);
        last_col_c   = (col == col_w'(width - 1));
        last_row_c   = (row == row_w'(height - 1));
        window_end_c = col[0] && row[0];
        px_ext_c     = {((is_signed != 0) ? bus.data_in[data_width-1] : 1'b0), bus.data_in};
        pair_ext_c   = {((is_signed != 0) ? pair_q[data_width-1] : 1'b0), pair_q};
        lb_rd_c      = line_buf[lb_idx_c];
        h_c          = '0;
        sum_c        = '0;
        result_c     = '0;
        if (mode == 0) begin
            h_c      = ($signed(pair_ext_c) > $signed(px_ext_c)) ? pair_ext_c : px_ext_c;
            result_c = ($signed(lb_rd_c) > $signed(h_c)) ? data_width'(lb_rd_c) : data_width'(h_c);
        end else begin
            h_c      = pair_ext_c + px_ext_c;
            sum_c    = {((is_signed != 0) ? lb_rd_c[hw-1] : 1'b0), lb_rd_c}
                     + {((is_signed != 0) ? h_c[hw-1] : 1'b0), h_c};
            // Truncation after the shift discards the fill bits, so floor is the same for both signednesses.
            result_c = data_width'(sum_c >> 2);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col     <= '0;
            row     <= '0;
            pair_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < int'(lb_n); i++) begin
                line_buf[i] <= '0;
            end
        end else if (bus.valid_in) begin
            if (last_col_c) begin
                col <= '0;
                row <= last_row_c ? '0 : row + row_w'(1);
            end else begin
                col <= col + col_w'(1);
            end

            if (!col[0]) begin
                pair_q <= bus.data_in;
            end else if (!row[0]) begin
                line_buf[lb_idx_c] <= h_c;
            end

            valid_q <= window_end_c;
            done_q  <= window_end_c && last_col_c && last_row_c;
            if (window_end_c) begin
                data_q <= result_c;
            end
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.valid_out  = valid_q;
    assign bus.frame_done = done_q;
endmodule

// File: doc/pooling_unit.md
Name: pooling_unit

Overview:
Streaming 2x2, stride-2 pooling engine for the CNN feature-map datapath. It is the parametrised successor of the fixed max-pooling block and adds:
- configurable frame width and height
- selectable max or average mode
- signed or unsigned arithmetic
- a frame-completion strobe

It accepts one pixel per valid cycle in raster order from the preceding conv/activation stage and emits pooled pixels in raster order to the next layer.

Parameters:
data_width, 32, pixel bit width (input and output)
width, 4, feature-map columns; even, >=2
height, 4, feature-map rows; even, >=2
mode, 0, 0 = max pooling, 1 = average pooling
is_signed, 1, 1 = two's-complement compare/sum, 0 = unsigned

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
data_in  input  data_width  input pixel, raster order
valid_in  input  1  data_in valid this cycle; no backpressure, source may insert gaps
data_out  output  data_width  pooled pixel
valid_out  output  1  data_out valid, single-cycle pulse per pooled pixel
frame_done  output  1  pulses together with the last pooled pixel of a frame

Behaviour:
- Reset (reset = 0, async) clears:
  - data_out = 0, valid_out = 0, frame_done = 0
  - col = 0, row = 0
  - pair register and all line-buffer entries = 0
  - Release is synchronous to clk.
- Counters:
  - col (0..width-1) and row (0..height-1) advance only on cycles with valid_in = 1.
  - col wraps to 0 and increments row; row wraps to 0 after the last pixel (width-1, height-1). The next frame starts immediately with no idle cycle.
  - valid_in = 0: all state holds.
- Horizontal stage:
  - Even col: latch data_in into the pair register.
  - Odd col: combine the pair register with data_in to form h.
    - Max mode: h = larger of the two.
    - Avg mode: h = sum, data_width+1 bits, sign-extended when is_signed = 1.
- Vertical stage:
  - Line buffer has width/2 entries, each data_width+1 bits, indexed col>>1.
  - Even row, odd col: write h into the entry.
  - Odd row, odd col: combine the entry with h.
    - Max mode: larger of the two.
    - Avg mode: 4-pixel sum in data_width+2 bits, then arithmetic (signed) or logical (unsigned) shift right by 2, i.e. floor. Truncate to data_width.
- Output:
  - Registered. valid_out = 1 and data_out = result in the cycle after the clock edge that sampled the odd-row/odd-col pixel. Latency is 1 cycle from the completing input.
  - Otherwise valid_out = 0 and data_out holds its last value.
- frame_done = 1 in the same cycle as the valid_out of pooled pixel (width/2-1, height/2-1); 0 otherwise.
- Outputs per frame: exactly (width/2)*(height/2).
- Equal operands in max mode: either operand (identical value).
- Reset asserted mid-frame:
  - Partial results are discarded and the in-flight valid_out is cleared.
  - After release, the next valid pixel is treated as (0,0).
- Odd width or height is illegal. An elaboration-time check stops simulation with an error.

Test Plan:
- Max, unsigned ramp: width = height = 4, mode = 0, inputs 1..16 contiguous.
  - Required: valid_out pulses carry 6, 8, 14, 16.
  - Each pulse occurs 1 cycle after inputs 6, 8, 14, 16 are sampled.
  - frame_done is high only with 16.
- Average mode, same ramp: mode = 1.
  - Required outputs 3, 5, 11, 13 (e.g. (1+2+5+6)/4 = 3.5 floors to 3).
- Signed negatives: width = height = 2, is_signed = 1, inputs -1, -2, -5, -6.
  - mode = 0: output -1.
  - mode = 1: output -4 (-14 >> 2 floors).
  - Same inputs with is_signed = 0, mode = 0: output 0xFFFFFFFF.
- Gapped input: 4x4 ramp with valid_in deasserted for 1–3 random cycles between pixels.
  - Required: same values as the max ramp (6, 8, 14, 16), each 1 cycle after its completing pixel; no extra valid_out pulses.
- Back-to-back frames: width = 6, height = 4, two contiguous frames.
  - Frame 1 ramp 1..24, frame 2 ramp 101..124.
  - Required outputs: 8, 10, 12, 20, 22, 24, then 108, 110, 112, 120, 122, 124.
  - frame_done pulses twice, with 24 and with 124.
- Reset mid-frame: assert reset = 0 asynchronously after pixel 7 of a 4x4 ramp.
  - Required: outputs go to 0 immediately, without waiting for a clock edge.
  - After release, a fresh 1..16 ramp yields exactly 6, 8, 14, 16 with no stale data.
